oam_dma_controller: RTL

Sequencer and bus arbiter for NES sprite DMA, sitting between the CPU_2A03 wrapper and the system memory map. It snoops CPU writes to the DMA register ($4014), halts the CPU by gating its ENABLE, then takes ownership of the CPU bus. It copies the 256-byte page {page, 8'h00..8'hFF} to the PPU OAM data port ($2004) as alternating read/write CPU cycles, and returns the bus to the CPU when done.

---
 rtl/oam_dma_controller.sv | 115 +++++++++++
 1 files changed

// File: rtl/oam_dma_controller.sv
// rtl/oam_dma_controller.sv - NES sprite DMA sequencer: halts the CPU and copies a 256-byte page to $2004
module oam_dma_controller (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        CPU_CE,
    input  logic [15:0] CPU_ADDR,
    input  logic [7:0]  CPU_DATA_OUT,
    input  logic        CPU_RW_n,
    output logic        CPU_ENABLE,
    output logic [15:0] BUS_ADDR,
    output logic [7:0]  BUS_DATA_OUT,
    output logic        BUS_RW_n,
    input  logic [7:0]  BUS_DATA_IN,
    output logic        DMA_ACTIVE
);

    localparam logic [15:0] DMA_REG  = 16'h4014;
    localparam logic [15:0] OAM_ADDR = 16'h2004;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_ALIGN,
        ST_READ,
        ST_WRITE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic        cyc_odd_q, cyc_odd_d;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q   <= ST_IDLE;
            page_q    <= 8'h00;
            idx_q     <= 8'h00;
            data_q    <= 8'h00;
            cyc_odd_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            page_q    <= page_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            cyc_odd_q <= cyc_odd_d;
        end
    end

    // Every register only moves on a CPU_CE edge, so a stretched CPU cycle
    // leaves the bus drive untouched for all of its CLKs.
    always_comb begin
        state_d      = state_q;
        page_d       = page_q;
        idx_d        = idx_q;
        data_d       = data_q;
        cyc_odd_d    = cyc_odd_q ^ CPU_CE;
        CPU_ENABLE   = 1'b0;
        BUS_ADDR     = CPU_ADDR;
        BUS_DATA_OUT = CPU_DATA_OUT;
        BUS_RW_n     = CPU_RW_n;

        case (state_q)
            ST_IDLE: begin
                CPU_ENABLE = CPU_CE;
                if (CPU_CE && !CPU_RW_n && (CPU_ADDR == DMA_REG)) begin
                    page_d  = CPU_DATA_OUT;
                    idx_d   = 8'h00;
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                BUS_ADDR     = {page_q, 8'h00};
                BUS_RW_n     = 1'b1;
                BUS_DATA_OUT = data_q;
                // An odd HALT cycle means the next cycle is already even.
                if (CPU_CE) begin
                    state_d = cyc_odd_q ? ST_READ : ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                BUS_ADDR     = {page_q, 8'h00};
                BUS_RW_n     = 1'b1;
                BUS_DATA_OUT = data_q;
                if (CPU_CE) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                BUS_ADDR     = {page_q, idx_q};
                BUS_RW_n     = 1'b1;
                BUS_DATA_OUT = data_q;
                if (CPU_CE) begin
                    data_d  = BUS_DATA_IN;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                BUS_ADDR     = OAM_ADDR;
                BUS_RW_n     = 1'b0;
                BUS_DATA_OUT = data_q;
                if (CPU_CE) begin
                    idx_d   = idx_q + 8'h01;
                    state_d = (idx_q == 8'hFF) ? ST_IDLE : ST_READ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign DMA_ACTIVE = (state_q != ST_IDLE);

endmodule
